// File: rtl/conv_sa_sched.sv
// conv_sa_sched: sequences a 3x3 convolution over a 4x4 unsigned map (2x2 result)
// onto an external sa2x2 weight-stationary systolic array.
//
// Operands are latched when start is accepted in IDLE. Five passes follow, each
// covering filter taps t0=2p and t1=2p+1 (tap 9 is a zero pad):
//   LOAD   2 cycles  : shift W[t1] then W[t0] into column 1
//   STREAM 5 cycles  : row 1 gets tap t0 of pixels 0..3, row 2 gets tap t1 one cycle later
//   DRAIN  SA_LAT    : activations 0 while the last pixels travel through the array
// psum_out1 of pixel o is accumulated SA_LAT cycles after its row-1 activation.
// Sums wrap modulo 2^DW.
//
// Ports:
//   clk, rst (async, active-high)       clock / reset
//   start                               one-cycle request, honoured only in IDLE
//   w_11..w_33, in_11..in_44            filter taps and input map
//   sa_weight_load, sa_w_in1/2          weight shift control and data to sa2x2
//   sa_act_in1/2, sa_psum_in1/2         activations and (zero) psum inputs to sa2x2
//   sa_psum_out1/2                      sa2x2 psums; only column 1 is used
//   conv_out_11..22                     published results, held until the next done
//   busy, done                          status; done pulses for one cycle on publish
module conv_sa_sched #(
  parameter int SA_LAT = 3,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] w_11, w_12, w_13,
  input  logic [DW-1:0] w_21, w_22, w_23,
  input  logic [DW-1:0] w_31, w_32, w_33,
  input  logic [DW-1:0] in_11, in_12, in_13, in_14,
  input  logic [DW-1:0] in_21, in_22, in_23, in_24,
  input  logic [DW-1:0] in_31, in_32, in_33, in_34,
  input  logic [DW-1:0] in_41, in_42, in_43, in_44,
  output logic          sa_weight_load,
  output logic [DW-1:0] sa_w_in1,
  output logic [DW-1:0] sa_w_in2,
  output logic [DW-1:0] sa_act_in1,
  output logic [DW-1:0] sa_act_in2,
  output logic [DW-1:0] sa_psum_in1,
  output logic [DW-1:0] sa_psum_in2,
  input  logic [DW-1:0] sa_psum_out1,
  input  logic [DW-1:0] sa_psum_out2,
  output logic [DW-1:0] conv_out_11,
  output logic [DW-1:0] conv_out_12,
  output logic [DW-1:0] conv_out_21,
  output logic [DW-1:0] conv_out_22,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // k counts LOAD cycles, then STREAM+DRAIN cycles from stream cycle 0.
  localparam int            KW      = $clog2(SA_LAT + 6);
  localparam logic [KW-1:0] K_LAST  = KW'(SA_LAT + 4);
  // The final drain cycle of the last pass carries no capture, so DONE takes
  // its slot; this keeps start-to-done at 5*(7+SA_LAT) cycles.
  localparam logic [KW-1:0] K_FINAL = KW'(SA_LAT + 3);

  logic [8:0][DW-1:0]  w_s, w_q, w_d;
  logic [15:0][DW-1:0] in_s, in_q, in_d;
  logic [2:0]          state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [2:0]          p_q, p_d;
  logic [3:0][DW-1:0]  acc_q, acc_d;
  logic [3:0][DW-1:0]  conv_q, conv_d;
  logic                accept_s;
  logic                wl_q, wl_d, busy_q, busy_d, done_q, done_d;
  logic [DW-1:0]       w_in1_q, w_in1_d, act1_q, act1_d, act2_q, act2_d;
  logic [3:0]          t0_s, t1_s;
  logic [1:0]          km1_s;
  logic                psum2_unused_s;

  assign w_s  = {w_33, w_32, w_31, w_23, w_22, w_21, w_13, w_12, w_11};
  assign in_s = {in_44, in_43, in_42, in_41, in_34, in_33, in_32, in_31,
                 in_24, in_23, in_22, in_21, in_14, in_13, in_12, in_11};
  assign psum2_unused_s = ^sa_psum_out2;

  // Weight of tap t; the pad tap 9 (and beyond) reads as zero.
  function automatic logic [DW-1:0] tap_w(input logic [8:0][DW-1:0] w, input logic [3:0] t);
    if (t < 4'd9) tap_w = w[t];
    else          tap_w = '0;
  endfunction

  // Activation for tap t of output pixel o: in[r+t/3][c+t%3] with r=o[1], c=o[0].
  function automatic logic [DW-1:0] tap_a(input logic [15:0][DW-1:0] m,
                                          input logic [3:0] t, input logic [1:0] o);
    logic [1:0] dr, dc, row, col;
    case (t)
      4'd0:    begin dr = 2'd0; dc = 2'd0; end
      4'd1:    begin dr = 2'd0; dc = 2'd1; end
      4'd2:    begin dr = 2'd0; dc = 2'd2; end
      4'd3:    begin dr = 2'd1; dc = 2'd0; end
      4'd4:    begin dr = 2'd1; dc = 2'd1; end
      4'd5:    begin dr = 2'd1; dc = 2'd2; end
      4'd6:    begin dr = 2'd2; dc = 2'd0; end
      4'd7:    begin dr = 2'd2; dc = 2'd1; end
      4'd8:    begin dr = 2'd2; dc = 2'd2; end
      default: begin dr = 2'd0; dc = 2'd0; end
    endcase
    row = {1'b0, o[1]} + dr;
    col = {1'b0, o[0]} + dc;
    if (t < 4'd9) tap_a = m[{row, col}];
    else          tap_a = '0;
  endfunction

  // Sequencer next state, operand latch and psum accumulation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    p_d      = p_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_d  = S_LOAD;
          k_d      = '0;
          p_d      = 3'd0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        if (k_q == KW'(1)) begin
          state_d = S_STREAM;
          k_d     = '0;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      S_STREAM: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(4)) state_d = S_DRAIN;
        else               state_d = S_STREAM;
      end
      S_DRAIN: begin
        if (p_q == 3'd4 && k_q == K_FINAL) begin
          state_d = S_DONE;
          k_d     = '0;
        end else if (k_q == K_LAST) begin
          state_d = S_LOAD;
          k_d     = '0;
          p_d     = p_q + 3'd1;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        p_d     = 3'd0;
      end
    endcase

    if (accept_s) begin
      w_d  = w_s;
      in_d = in_s;
    end else begin
      w_d  = w_q;
      in_d = in_q;
    end

    acc_d = acc_q;
    if (accept_s) begin
      acc_d = '0;
    end else if (state_q == S_STREAM || state_q == S_DRAIN) begin
      for (int o = 0; o < 4; o++) begin
        if (k_q == KW'(o + SA_LAT)) acc_d[o] = acc_q[o] + sa_psum_out1;
        else                        acc_d[o] = acc_q[o];
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Output next values, derived from the next state so the ports are registered
  // yet line up with the cycle the sequencer is in.
  always_comb begin
    t0_s    = {p_d, 1'b0};
    t1_s    = {p_d, 1'b1};
    km1_s   = k_d[1:0] - 2'd1;
    wl_d    = 1'b0;
    w_in1_d = '0;
    act1_d  = '0;
    act2_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    conv_d  = conv_q;
    case (state_d)
      S_LOAD: begin
        wl_d   = 1'b1;
        busy_d = 1'b1;
        // t1 goes in first so it ends up in row 2, t0 in row 1.
        if (k_d == '0) w_in1_d = tap_w(w_d, t1_s);
        else           w_in1_d = tap_w(w_d, t0_s);
      end
      S_STREAM: begin
        busy_d = 1'b1;
        if (k_d < KW'(4)) act1_d = tap_a(in_d, t0_s, k_d[1:0]);
        else              act1_d = '0;
        // Row 2 is skewed one cycle behind row 1.
        if (k_d != '0)    act2_d = tap_a(in_d, t1_s, km1_s);
        else              act2_d = '0;
      end
      S_DRAIN: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        conv_d = acc_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, operand, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      p_q     <= 3'd0;
      w_q     <= '0;
      in_q    <= '0;
      acc_q   <= '0;
      conv_q  <= '0;
      wl_q    <= 1'b0;
      w_in1_q <= '0;
      act1_q  <= '0;
      act2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      w_q     <= w_d;
      in_q    <= in_d;
      acc_q   <= acc_d;
      conv_q  <= conv_d;
      wl_q    <= wl_d;
      w_in1_q <= w_in1_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sa_weight_load = wl_q;
  assign sa_w_in1       = w_in1_q;
  assign sa_w_in2       = '0;
  assign sa_act_in1     = act1_q;
  assign sa_act_in2     = act2_q;
  assign sa_psum_in1    = '0;
  assign sa_psum_in2    = '0;
  assign conv_out_11    = conv_q[0];
  assign conv_out_12    = conv_q[1];
  assign conv_out_21    = conv_q[2];
  assign conv_out_22    = conv_q[3];
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_conv_sa_sched.sv
// Bench for conv_sa_sched: drives operand vectors, emulates the sa2x2 array
// behaviourally and compares published results with a direct convolution.
module tb_conv_sa_sched;

  typedef struct packed {
    logic [8:0][7:0]  w;
    logic [15:0][7:0] m;
    logic [3:0][7:0]  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [8:0][7:0]  w_drv = '0;
  logic [15:0][7:0] m_drv = '0;
  logic       sa_weight_load;
  logic [7:0] sa_w_in1, sa_w_in2, sa_act_in1, sa_act_in2, sa_psum_in1, sa_psum_in2;
  logic [7:0] sa_psum_out1 = 8'd0;
  logic [7:0] sa_psum_out2 = 8'd0;
  logic [7:0] conv_out_11, conv_out_12, conv_out_21, conv_out_22;
  logic       busy, done;
  logic [31:0] res_s;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int inv_err = 0;
  logic [3:0][7:0] prev_exp = '0;
  vec_t tbl [10];

  assign res_s = {conv_out_22, conv_out_21, conv_out_12, conv_out_11};

  conv_sa_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .w_11(w_drv[0]), .w_12(w_drv[1]), .w_13(w_drv[2]),
    .w_21(w_drv[3]), .w_22(w_drv[4]), .w_23(w_drv[5]),
    .w_31(w_drv[6]), .w_32(w_drv[7]), .w_33(w_drv[8]),
    .in_11(m_drv[0]),  .in_12(m_drv[1]),  .in_13(m_drv[2]),  .in_14(m_drv[3]),
    .in_21(m_drv[4]),  .in_22(m_drv[5]),  .in_23(m_drv[6]),  .in_24(m_drv[7]),
    .in_31(m_drv[8]),  .in_32(m_drv[9]),  .in_33(m_drv[10]), .in_34(m_drv[11]),
    .in_41(m_drv[12]), .in_42(m_drv[13]), .in_43(m_drv[14]), .in_44(m_drv[15]),
    .sa_weight_load(sa_weight_load), .sa_w_in1(sa_w_in1), .sa_w_in2(sa_w_in2),
    .sa_act_in1(sa_act_in1), .sa_act_in2(sa_act_in2),
    .sa_psum_in1(sa_psum_in1), .sa_psum_in2(sa_psum_in2),
    .sa_psum_out1(sa_psum_out1), .sa_psum_out2(sa_psum_out2),
    .conv_out_11(conv_out_11), .conv_out_12(conv_out_12),
    .conv_out_21(conv_out_21), .conv_out_22(conv_out_22),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sa2x2 stand-in: column 1 psum = row1 weight * row1 act (3 cycles ago)
  // + row2 weight * row2 act (2 cycles ago, row 2 being fed one cycle late).
  logic [7:0] a1h [4096];
  logic [7:0] a2h [4096];
  logic [7:0] wr1 = 8'd0;
  logic [7:0] wr2 = 8'd0;
  always @(negedge clk) begin
    int pv;
    a1h[cyc % 4096] = sa_act_in1;
    a2h[cyc % 4096] = sa_act_in2;
    if (cyc >= 3) begin
      pv = int'(wr1) * int'(a1h[(cyc - 3) % 4096]) + int'(wr2) * int'(a2h[(cyc - 2) % 4096]);
      sa_psum_out1 = 8'(pv);
    end
    sa_psum_out2 = 8'($urandom);
    if (sa_weight_load) begin
      wr2 = wr1;
      wr1 = sa_w_in1;
    end
    if (!rst) begin
      if ({sa_w_in2, sa_psum_in1, sa_psum_in2} != 24'd0) inv_err++;
      if (!busy && {sa_weight_load, sa_w_in1, sa_act_in1, sa_act_in2} != 25'd0) inv_err++;
    end
  end

  function automatic logic [3:0][7:0] conv_ref(input logic [8:0][7:0] w, input logic [15:0][7:0] m);
    logic [3:0][7:0] r;
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++) begin
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(w[3*i+j]) * int'(m[(rr+i)*4 + cc + j]);
        r[2*rr+cc] = 8'(s);
      end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_op(input vec_t v, input bit reassert, input vec_t alt);
    int s0, busy_cnt, hold_bad;
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    w_drv = v.w;
    m_drv = v.m;
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 9; t++)  w_drv[t] = 8'($urandom);
    for (int t = 0; t < 16; t++) m_drv[t] = 8'($urandom);
    busy_cnt = 0;
    hold_bad = 0;
    while (done !== 1'b1 && cyc - s0 < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (res_s !== prev_exp) hold_bad++;
      if (reassert && cyc - s0 == 20) begin
        start = 1'b1;
        w_drv = alt.w;
        m_drv = alt.m;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("latency", 64'(cyc - s0), 64'd50);
    chk("busy_cycles", 64'(busy_cnt), 64'd49);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("hold_prev", 64'(hold_bad), 64'd0);
    chk("result", {32'd0, res_s}, {32'd0, v.e});
    prev_exp = v.e;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Directed vectors with hand-derived results.
    tbl[0].w = {9{8'd1}};  tbl[0].m = {16{8'd1}};  tbl[0].e = {4{8'd9}};
    tbl[1].w = '0; tbl[1].w[4] = 8'd1;
    for (int x = 1; x <= 4; x++)
      for (int y = 1; y <= 4; y++)
        tbl[1].m[(x-1)*4 + (y-1)] = 8'(10*x + y);
    tbl[1].e[0] = 8'd22; tbl[1].e[1] = 8'd23; tbl[1].e[2] = 8'd32; tbl[1].e[3] = 8'd33;
    tbl[2].w = {9{8'd3}};  tbl[2].m = {16{8'd10}}; tbl[2].e = {4{8'd14}};
    // All-max operands: 9*255*255 mod 256 = 9.
    tbl[3].w = {9{8'd255}}; tbl[3].m = {16{8'd255}}; tbl[3].e = {4{8'd9}};
    // Random vectors checked against the direct convolution.
    for (int k = 4; k < 10; k++) begin
      for (int t = 0; t < 9; t++)  tbl[k].w[t] = 8'($urandom);
      for (int t = 0; t < 16; t++) tbl[k].m[t] = 8'($urandom);
      tbl[k].e = conv_ref(tbl[k].w, tbl[k].m);
    end

    repeat (2) @(negedge clk);
    chk("reset_sa", {15'd0, sa_weight_load, sa_w_in1, sa_w_in2, sa_act_in1,
                     sa_act_in2, sa_psum_in1, sa_psum_in2}, 64'd0);
    chk("reset_out", {30'd0, res_s, busy, done}, 64'd0);
    rst = 1'b0;

    // Back-to-back operations: each starts the cycle after the previous done.
    for (int k = 0; k < 10; k++) run_op(tbl[k], 1'b0, tbl[0]);

    // A start while busy (with different operands) must be ignored.
    run_op(tbl[5], 1'b1, tbl[2]);

    // Reset in the middle of an operation.
    @(negedge clk);
    w_drv = tbl[2].w; m_drv = tbl[2].m; start = 1'b1;
    begin
      int s0;
      s0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc - s0 < 25) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_sa", {15'd0, sa_weight_load, sa_w_in1, sa_w_in2, sa_act_in1,
                       sa_act_in2, sa_psum_in1, sa_psum_in2}, 64'd0);
    chk("rst_mid_out", {30'd0, res_s, busy, done}, 64'd0);
    @(negedge clk);
    chk("rst_held_out", {30'd0, res_s, busy, done}, 64'd0);
    rst = 1'b0;
    prev_exp = '0;
    run_op(tbl[6], 1'b0, tbl[0]);
    run_op(tbl[0], 1'b0, tbl[0]);

    chk("port_invariants", 64'(inv_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
